capture_trigger_ctrl: RTL and testbench
=======================================

Name: capture_trigger_ctrl

Overview:
- Write-side front end for the variable-width pre-trigger capture FIFO.
- Takes raw ADC samples, decimates them, and enforces a minimum pre-trigger fill.
- Detects the trigger condition and drives the FIFO's write data, write enable, one-shot trigger and FIFO reset.
- Sequences arm → pre-fill → armed → capture → done, using the FIFO's write-done flag to end capture.

Parameters:
- data_width, 10, ADC sample width; equals the FIFO write data width.
- ds_width, 16, width of the decimation factor.

Ports:
- wr_clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  level; a rising edge starts a capture, low aborts or returns to idle.
- adc_data  in  data_width  one sample per clock.
- trigger_in  in  1  asynchronous trigger source.
- trigger_mode  in  2  00 rising, 01 falling, 10 high, 11 low.
- trigger_now  in  1  one-cycle software force trigger.
- downsample  in  ds_width  keep 1 of N samples; 0 and 1 both mean every sample.
- presamples  in  32  decimated samples to write before triggers are accepted.
- fifo_wr_done  in  1  FIFO capture-complete flag.
- fifo_rst  out  1  one-cycle FIFO reset.
- fifo_wr_data  out  data_width  sample to the FIFO.
- fifo_wr_ce  out  1  FIFO write enable.
- fifo_wr_trigger  out  1  one-shot trigger; only ever asserted together with fifo_wr_ce.
- armed  out  1  high in ARMED.
- capturing  out  1  high in CAPTURE.
- done  out  1  high in DONE.

Behaviour:
- All outputs are registered; every output resets to 0; the state resets to IDLE.
- arm is registered once; arm_rise = arm_q & ~arm_qq.
- trigger_in passes through a 2-flop synchronizer, then one history flop.
  - Rising: s & ~h. Falling: ~s & h. High: s. Low: ~s.
  - trig_evt = that result OR trigger_now.
- Decimation counter ds_cnt:
  - Cleared in IDLE.
  - Otherwise counts 0..max(downsample,1)-1 and wraps.
  - strobe = (ds_cnt==0).
  - A change to downsample while running takes effect at the next wrap.
- fifo_wr_data <= adc_data on every cycle. fifo_wr_ce <= strobe & (state in PRETRIG, ARMED, CAPTURE).
- Write latency: the sample on adc_data at cycle N appears on fifo_wr_data/fifo_wr_ce at N+1.
- IDLE:
  - On arm_rise: pulse fifo_rst for 1 cycle, clear pre_cnt, go to PRETRIG.
  - No FIFO writes in IDLE.
- PRETRIG:
  - pre_cnt increments on each strobe.
  - Go to ARMED when pre_cnt == presamples; presamples = 0 means ARMED on the next cycle.
  - trig_evt is ignored in PRETRIG and is not latched.
- ARMED:
  - trig_evt sets trig_pend.
  - On the first strobe with trig_pend or trig_evt: assert fifo_wr_trigger with that fifo_wr_ce, clear trig_pend, go to CAPTURE.
  - Decimation is therefore never broken by a trigger; the trigger lands on a written sample.
- CAPTURE:
  - Keep writing on strobe; fifo_wr_trigger stays 0.
  - On fifo_wr_done = 1: go to DONE. fifo_wr_ce is 0 from that cycle's output onward.
- DONE:
  - done = 1, no writes.
  - arm low → IDLE. Re-arming needs a fresh arm_rise; holding arm high never restarts.
- Abort: arm low in PRETRIG, ARMED or CAPTURE → IDLE next cycle.
  - fifo_wr_ce forced 0 the same cycle the registered arm is seen low.
  - trig_pend cleared.
- rst mid-operation: all state and outputs return to reset values next cycle. fifo_rst is not pulsed; the FIFO shares rst.
- Simultaneous events:
  - arm_rise in DONE or IDLE takes priority.
  - fifo_wr_done while in PRETRIG or ARMED is ignored (stale flag; fifo_rst clears it).
  - trig_evt on the same cycle ARMED is entered is accepted.

Optional Feature:
- Macro: CAPTURE_TRIG_TIMESTAMP_EN.
- Defined:
  - Adds output trig_sample_cnt[31:0], which counts strobes from arm_rise (cleared there).
  - Frozen on the cycle fifo_wr_trigger is issued; holds until the next arm_rise.
  - Saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then arm_rise with downsample=1, presamples=8, trigger_mode=00:
  - fifo_rst pulses 1 cycle.
  - Exactly 8 writes occur before armed=1.
  - A trigger_in pulse issued during PRETRIG produces no fifo_wr_trigger.
- downsample=4, presamples=3, ramp adc_data 0,1,2...:
  - fifo_wr_data sequence is 0,4,8,...
  - armed after the 3rd write.
  - trigger edge at sample 21 → fifo_wr_trigger with data 24, capturing=1.
- trigger_mode=11 with trigger_in held low on entering ARMED → trigger on the first strobe in ARMED. trigger_now in mode 10 with trigger_in low → trigger on the next strobe.
- In CAPTURE, assert fifo_wr_done → done=1, fifo_wr_ce=0 thereafter. Hold arm high 20 cycles → no restart. Drop arm, raise it → new fifo_rst and PRETRIG.
- Drop arm mid-CAPTURE → IDLE, fifo_wr_ce=0 within 2 cycles. Assert rst in ARMED → all outputs 0 next cycle, state IDLE.
- With CAPTURE_TRIG_TIMESTAMP_EN, downsample=1, presamples=5, trigger at the 12th strobe → trig_sample_cnt=12, held through DONE.

Source files
------------

// File: rtl/capture_trigger_ctrl.sv
// Decimating write-side front end for the pre-trigger capture FIFO; trigger
// detect, pre-fill and sequencing. Define CAPTURE_TRIG_TIMESTAMP_EN for trig_sample_cnt.
// Latency: adc_data at cycle N reaches fifo_wr_data/fifo_wr_ce at N+1. No backpressure; the FIFO always accepts.
module capture_trigger_ctrl #(
  parameter int data_width = 10,
  parameter int ds_width   = 16
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic [data_width-1:0] adc_data,
  input  logic                  trigger_in,
  input  logic [1:0]            trigger_mode,
  input  logic                  trigger_now,
  input  logic [ds_width-1:0]   downsample,
  input  logic [31:0]           presamples,
  input  logic                  fifo_wr_done,
  output logic                  fifo_rst,
  output logic [data_width-1:0] fifo_wr_data,
  output logic                  fifo_wr_ce,
  output logic                  fifo_wr_trigger,
  output logic                  armed,
  output logic                  capturing,
  output logic                  done
`ifdef CAPTURE_TRIG_TIMESTAMP_EN
  ,
  output logic [31:0]           trig_sample_cnt
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PRETRIG = 3'd1;
  localparam logic [2:0] S_ARMED   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [ds_width-1:0] DS_ONE = {{(ds_width-1){1'b0}}, 1'b1};

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic                arm_q;
  logic                arm_qq;
  logic                arm_rise;
  logic                trig_s1;
  logic                trig_s2;
  logic                trig_h;
  logic                trig_lvl;
  logic                trig_evt;
  logic                trig_pend;
  logic                take_trig;
  logic [ds_width-1:0] ds_cnt;
  logic [ds_width-1:0] ds_cnt_inc;
  logic [ds_width-1:0] ds_max;
  logic [ds_width-1:0] ds_lim;
  logic                strobe;
  logic [31:0]         pre_cnt;
  logic                running;
  logic                restart;
  logic                wr_en;

  assign arm_rise   = arm_q & ~arm_qq;
  assign running    = (state == S_PRETRIG) || (state == S_ARMED) || (state == S_CAPTURE);
  // A fresh arm edge only starts a capture from rest; in the active states it
  // cannot occur without arm having been seen low, which already aborted.
  assign restart    = arm_rise && ((state == S_IDLE) || (state == S_DONE));
  assign ds_lim     = (downsample == '0) ? DS_ONE : downsample;
  assign ds_cnt_inc = ds_cnt + DS_ONE;
  assign strobe     = (ds_cnt == '0) && (state != S_IDLE);
  // Write on the decimation strobe while active, except on the cycle arm is
  // seen low (abort) or the FIFO reports capture complete.
  assign wr_en      = strobe && running && arm_q &&
                      !((state == S_CAPTURE) && fifo_wr_done);

  // Trigger condition selected from the synchronized level and its history.
  always_comb begin
    trig_lvl = 1'b0;
    case (trigger_mode)
      2'b00:   trig_lvl = trig_s2 & ~trig_h;
      2'b01:   trig_lvl = ~trig_s2 & trig_h;
      2'b10:   trig_lvl = trig_s2;
      default: trig_lvl = ~trig_s2;
    endcase
    trig_evt = trig_lvl | trigger_now;
  end

  // Sequencer next state; a trigger is only taken on a strobe so it always
  // rides on a written sample.
  always_comb begin
    state_nxt = state;
    take_trig = 1'b0;
    case (state)
      S_IDLE:    if (arm_rise) state_nxt = S_PRETRIG;
      S_PRETRIG: begin
        if (!arm_q)                        state_nxt = S_IDLE;
        else if (pre_cnt == presamples)    state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (!arm_q) state_nxt = S_IDLE;
        else if (strobe && (trig_pend || trig_evt)) begin
          take_trig = 1'b1;
          state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (!arm_q)            state_nxt = S_IDLE;
        else if (fifo_wr_done) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (arm_rise)   state_nxt = S_PRETRIG;
        else if (!arm_q) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Arm edge detect and the 2-flop trigger synchronizer plus history flop.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      arm_q   <= 1'b0;
      arm_qq  <= 1'b0;
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      trig_h  <= 1'b0;
    end else begin
      arm_q   <= arm;
      arm_qq  <= arm_q;
      trig_s1 <= trigger_in;
      trig_s2 <= trig_s1;
      trig_h  <= trig_s2;
    end
  end

  // Decimation counter; the factor is re-latched only at wrap so a change
  // never produces a short or long interval mid-period.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      ds_cnt <= '0;
      ds_max <= DS_ONE;
    end else if (state == S_IDLE) begin
      ds_cnt <= '0;
      ds_max <= ds_lim;
    end else if (ds_cnt_inc >= ds_max) begin
      ds_cnt <= '0;
      ds_max <= ds_lim;
    end else begin
      ds_cnt <= ds_cnt_inc;
    end
  end

  // Pre-fill counter and pending trigger; triggers are only remembered in ARMED.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      pre_cnt   <= '0;
      trig_pend <= 1'b0;
    end else begin
      if (restart)
        pre_cnt <= '0;
      else if ((state == S_PRETRIG) && strobe)
        pre_cnt <= pre_cnt + 32'd1;
      if ((state == S_ARMED) && (state_nxt == S_ARMED))
        trig_pend <= trig_pend | trig_evt;
      else
        trig_pend <= 1'b0;
    end
  end

  // State register and all registered outputs.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state           <= S_IDLE;
      fifo_rst        <= 1'b0;
      fifo_wr_data    <= '0;
      fifo_wr_ce      <= 1'b0;
      fifo_wr_trigger <= 1'b0;
      armed           <= 1'b0;
      capturing       <= 1'b0;
      done            <= 1'b0;
    end else begin
      state           <= state_nxt;
      fifo_rst        <= restart;
      fifo_wr_data    <= adc_data;
      fifo_wr_ce      <= wr_en;
      fifo_wr_trigger <= take_trig;
      armed           <= (state_nxt == S_ARMED);
      capturing       <= (state_nxt == S_CAPTURE);
      done            <= (state_nxt == S_DONE);
    end
  end

`ifdef CAPTURE_TRIG_TIMESTAMP_EN
  logic ts_frozen;

  // Strobe count since arm, frozen on the strobe that carries the trigger.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      trig_sample_cnt <= '0;
      ts_frozen       <= 1'b0;
    end else if (restart) begin
      trig_sample_cnt <= '0;
      ts_frozen       <= 1'b0;
    end else if (strobe && !ts_frozen) begin
      if (trig_sample_cnt != 32'hFFFF_FFFF)
        trig_sample_cnt <= trig_sample_cnt + 32'd1;
      if (take_trig)
        ts_frozen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_capture_trigger_ctrl.sv
// Bench for capture_trigger_ctrl: vector table of full capture runs with a
// write scoreboard, plus hand sequences for reset, abort and reset-in-ARMED.
// Sampling is #1 after the rising edge; inputs are driven right after sampling.
module tb_capture_trigger_ctrl;
  localparam int DW = 10;
  localparam int SW = 16;

  logic          wr_clk = 1'b0;
  logic          rst;
  logic          arm;
  logic [DW-1:0] adc_data;
  logic          trigger_in;
  logic [1:0]    trigger_mode;
  logic          trigger_now;
  logic [SW-1:0] downsample;
  logic [31:0]   presamples;
  logic          fifo_wr_done;
  logic          fifo_rst;
  logic [DW-1:0] fifo_wr_data;
  logic          fifo_wr_ce;
  logic          fifo_wr_trigger;
  logic          armed;
  logic          capturing;
  logic          done;
`ifdef CAPTURE_TRIG_TIMESTAMP_EN
  logic [31:0]   trig_sample_cnt;
`endif

  capture_trigger_ctrl #(.data_width(DW), .ds_width(SW)) dut (
    .wr_clk          (wr_clk),
    .rst             (rst),
    .arm             (arm),
    .adc_data        (adc_data),
    .trigger_in      (trigger_in),
    .trigger_mode    (trigger_mode),
    .trigger_now     (trigger_now),
    .downsample      (downsample),
    .presamples      (presamples),
    .fifo_wr_done    (fifo_wr_done),
    .fifo_rst        (fifo_rst),
    .fifo_wr_data    (fifo_wr_data),
    .fifo_wr_ce      (fifo_wr_ce),
    .fifo_wr_trigger (fifo_wr_trigger),
    .armed           (armed),
    .capturing       (capturing),
    .done            (done)
`ifdef CAPTURE_TRIG_TIMESTAMP_EN
    ,
    .trig_sample_cnt (trig_sample_cnt)
`endif
  );

  always #5 wr_clk = ~wr_clk;

  // kind: 0 = 2-sample pulse on trigger_in at t_at, 1 = trigger_now at t_at, 2 = level only
  typedef struct {
    int         ds;
    int         pre;
    logic [1:0] mode;
    logic       idle;
    int         kind;
    int         t_at;
    int         fake_at;
    int         stale_at;
    int         exp_arm;
    int         exp_trig;
    int         done_at;
    int         exp_ts;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          trg;
  } exp_t;

  vec_t vt[7];
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic settle(input int n, input logic tin);
    arm          = 1'b0;
    trigger_in   = tin;
    trigger_now  = 1'b0;
    fifo_wr_done = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int   eff;
    int   last;
    int   rst_cnt, rst_at, arm_at, cap_at, done_seen, pre_writes, stray, hold_bad;
    int   cnt;
    logic found;
    logic pulse;
    exp_t e;

    // all runs start from adc sample 0 at the first PRETRIG cycle
    vt[0] = '{1, 8, 2'b00, 1'b0, 0, 15,  2,  3,  9, 17, 25, 18};
    vt[1] = '{4, 3, 2'b00, 1'b0, 0, 21, -1, 12, 10, 24, 33,  7};
    vt[2] = '{3, 2, 2'b11, 1'b0, 2, -1, -1, -1,  5,  6, 20,  3};
    vt[3] = '{2, 1, 2'b10, 1'b0, 1, 13, -1, -1,  2, 14, 22,  8};
    vt[4] = '{0, 0, 2'b01, 1'b1, 0,  4, -1, -1,  1,  6, 12,  7};
    vt[5] = '{1, 4, 2'b00, 1'b0, 0,  3, -1, -1,  5,  5, 10,  6};
    vt[6] = '{1, 5, 2'b10, 1'b0, 1, 11, -1, -1,  6, 11, 16, 12};

    // reset state
    rst = 1'b1; arm = 1'b0; adc_data = 10'h155; trigger_in = 1'b0; trigger_mode = 2'b00;
    trigger_now = 1'b0; downsample = 16'd1; presamples = 32'd8; fifo_wr_done = 1'b0;
    repeat (3) tick();
    chk("reset_fifo_rst", fifo_rst, 0);
    chk("reset_wr_data", fifo_wr_data, 0);
    chk("reset_wr_ce", fifo_wr_ce, 0);
    chk("reset_wr_trigger", fifo_wr_trigger, 0);
    chk("reset_armed", armed, 0);
    chk("reset_capturing", capturing, 0);
    chk("reset_done", done, 0);
`ifdef CAPTURE_TRIG_TIMESTAMP_EN
    chk("reset_ts", trig_sample_cnt, 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      eff          = (vt[i].ds < 2) ? 1 : vt[i].ds;
      downsample   = SW'(vt[i].ds);
      presamples   = 32'(vt[i].pre);
      trigger_mode = vt[i].mode;
      settle(6, vt[i].idle);
      rst_cnt = 0; rst_at = -999; arm_at = -999; cap_at = -999; done_seen = -999;
      pre_writes = 0; stray = 0; hold_bad = 0;
      last = vt[i].done_at + 22;
      for (int s = -2; s <= last; s++) begin
        // observe the cycle in which sample s is presented
        if (fifo_rst) begin
          rst_cnt++;
          if (rst_at == -999) rst_at = s;
        end
        if (armed && arm_at == -999) arm_at = s;
        if (capturing && cap_at == -999) cap_at = s;
        if (done && done_seen == -999) done_seen = s;
        if (fifo_wr_ce && arm_at == -999) pre_writes++;
        if (fifo_wr_trigger && !fifo_wr_ce) stray++;
        if (s > vt[i].done_at && (armed || capturing || fifo_rst || !done)) hold_bad++;
        if (fifo_wr_ce) begin
          if (sb.size() == 0) begin
            chk($sformatf("r%0d_unexpected_write_s%0d", i, s), 1, 0);
          end else begin
            e = sb.pop_front();
            chk($sformatf("r%0d_wr_data_s%0d", i, s), fifo_wr_data, e.dat);
            chk($sformatf("r%0d_wr_trigger_s%0d", i, s), fifo_wr_trigger, e.trg);
          end
        end
        // drive sample s
        arm      = 1'b1;
        adc_data = (s >= 0) ? DW'(s) : 10'h3AA;
        pulse    = (vt[i].kind == 0 && s >= vt[i].t_at && s < vt[i].t_at + 2) ||
                   (vt[i].fake_at >= 0 && s >= vt[i].fake_at && s < vt[i].fake_at + 2);
        trigger_in   = vt[i].idle ^ pulse;
        trigger_now  = (vt[i].kind == 1 && s == vt[i].t_at);
        fifo_wr_done = (s == vt[i].stale_at) || (s >= vt[i].done_at);
        if (s >= 0 && s < vt[i].done_at && (s % eff) == 0) begin
          e.dat = DW'(s);
          e.trg = (s == vt[i].exp_trig);
          sb.push_back(e);
        end
        tick();
      end
      chk($sformatf("r%0d_fifo_rst_pulses", i), rst_cnt, 1);
      chk($sformatf("r%0d_fifo_rst_cycle", i), rst_at, 0);
      chk($sformatf("r%0d_armed_at", i), arm_at, vt[i].exp_arm);
      chk($sformatf("r%0d_writes_before_armed", i), pre_writes, vt[i].pre);
      chk($sformatf("r%0d_capturing_at", i), cap_at, vt[i].exp_trig + 1);
      chk($sformatf("r%0d_done_at", i), done_seen, vt[i].done_at + 1);
      chk($sformatf("r%0d_stray_trigger", i), stray, 0);
      chk($sformatf("r%0d_hold_no_restart", i), hold_bad, 0);
      chk($sformatf("r%0d_missing_writes", i), sb.size(), 0);
`ifdef CAPTURE_TRIG_TIMESTAMP_EN
      chk($sformatf("r%0d_trig_sample_cnt", i), trig_sample_cnt, vt[i].exp_ts);
`endif
      sb.delete();
      arm = 1'b0;
      tick();
      tick();
      chk($sformatf("r%0d_done_clears", i), done, 0);
      fifo_wr_done = 1'b0;
    end

    // abort from CAPTURE: writes stop within two cycles of dropping arm
    downsample = 16'd1; presamples = 32'd2; trigger_mode = 2'b10;
    settle(6, 1'b1);
    arm = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      adc_data = DW'(k);
      tick();
      if (capturing) found = 1'b1;
    end
    chk("abort_reached_capture", found, 1);
    repeat (2) tick();
    chk("abort_writing_before", fifo_wr_ce, 1);
    arm = 1'b0;
    tick();
    tick();
    chk("abort_wr_ce", fifo_wr_ce, 0);
    chk("abort_capturing", capturing, 0);
    chk("abort_armed", armed, 0);
    chk("abort_done", done, 0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (fifo_wr_ce || fifo_rst) cnt++;
    end
    chk("abort_stays_idle", cnt, 0);

    // synchronous reset while ARMED
    presamples = 32'd3; trigger_mode = 2'b00;
    settle(6, 1'b0);
    arm = 1'b1;
    adc_data = 10'h2F0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (armed) found = 1'b1;
    end
    chk("rst_reached_armed", found, 1);
    rst = 1'b1;
    arm = 1'b0;
    tick();
    chk("rst_fifo_rst", fifo_rst, 0);
    chk("rst_wr_data", fifo_wr_data, 0);
    chk("rst_wr_ce", fifo_wr_ce, 0);
    chk("rst_wr_trigger", fifo_wr_trigger, 0);
    chk("rst_armed", armed, 0);
    chk("rst_capturing", capturing, 0);
    chk("rst_done", done, 0);
`ifdef CAPTURE_TRIG_TIMESTAMP_EN
    chk("rst_ts", trig_sample_cnt, 0);
`endif
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (armed || capturing || done || fifo_wr_ce || fifo_rst) cnt++;
    end
    chk("rst_stays_idle", cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
